clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Configuration controller for the system's programmable integer clock divider. It accepts divide-ratio change requests from two requesters, for example the UART TX/RX prescale path and the register file, and arbitrates between them round-robin. Each granted change is applied glitch-safely: the divider enable is gated off, the new ratio is loaded, the block waits a settle interval, then re-enables. It sits in the reference-clock domain next to the divider and drives the divider's ratio and enable inputs directly.

Parameters:
GATE_CYC, 2, cycles the divider enable is held low before the new ratio is driven (>=1)
SETTLE_CYC, 4, cycles the enable stays low after the ratio changes (>=1)
MAX_DIV, 8, largest legal ratio; 0 and 1 are legal and mean bypass at the divider
RESET_DIV, 1, ratio driven out of reset

Ports:
CLK_Ref  input  1  reference clock; all logic on rising edge
Reset  input  1  asynchronous, active-high reset
div_en  input  1  software enable for the divided clock
req0  input  1  requester 0 change request; level, held until ack0
div0  input  4  requester 0 requested ratio; stable while req0 is high
req1  input  1  requester 1 change request
div1  input  4  requester 1 requested ratio
ack0  output  1  one-cycle completion pulse to requester 0
ack1  output  1  one-cycle completion pulse to requester 1
err  output  1  qualifies ack: 1 = request rejected; valid only while ack0/ack1 is high
div_out  output  4  ratio to the divider; registered
clk_en_out  output  1  enable to the divider; registered
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): state=IDLE, div_out=RESET_DIV, clk_en_out=0, ack0=ack1=err=0, last_grant=1 (requester 0 wins the first tie), count=0. A pending request is discarded with no ack.
- All outputs are registered.
- States: IDLE, GATE, LOAD, SETTLE, RESP.
- IDLE:
  - clk_en_out <= div_en every cycle.
  - If any req is high, grant one requester. With only one request, that requester wins. With both high, the requester other than last_grant wins.
  - On grant: update last_grant, capture pend_div and grant id.
  - pend_div > MAX_DIV: go to RESP with err=1; div_out and clk_en_out are untouched.
  - pend_div == div_out: go to RESP with err=0; no gating.
  - Otherwise: go to GATE with clk_en_out <= 0 and count <= GATE_CYC-1.
- GATE: clk_en_out held 0. When count==0, go to LOAD; otherwise decrement count.
- LOAD: one cycle. div_out <= pend_div, count <= SETTLE_CYC-1, go to SETTLE.
- SETTLE: clk_en_out held 0. When count==0, go to RESP; otherwise decrement.
- RESP: one cycle.
  - Pulse ack of the granted requester for exactly one cycle; drive err as determined at grant.
  - clk_en_out <= div_en; go to IDLE.
- Requester handshake:
  - A requester must drop req at the clock edge that ends its ack cycle, so req is low in the following IDLE cycle. A req still high in that cycle is a new request.
  - A req that rises during a sequence waits in IDLE arbitration; it is never lost.
- Latency: a grant at edge E0 produces ack in the cycle following edge E0+GATE_CYC+SETTLE_CYC+1. Rejected and no-change requests produce ack in the cycle after E0.
- div_en changes during GATE, LOAD or SETTLE have no effect until RESP. In IDLE, clk_en_out follows div_en with one cycle of latency.
- div_out changes only in LOAD. clk_en_out is guaranteed 0 for GATE_CYC cycles before and SETTLE_CYC cycles after any div_out change.
- Non-granted req and div inputs are ignored outside IDLE. div values above 15 cannot occur (4-bit port).

Test Plan:
- Reset release, div_en=1, no req -> div_out=1; clk_en_out 0 during reset, then 1 one cycle after the first IDLE edge; busy=0.
- req0 with div0=6 (GATE_CYC=2, SETTLE_CYC=4) -> clk_en_out 0 for 7 cycles; div_out=6 after LOAD; single ack0 with err=0 in the cycle after edge E0+7; clk_en_out back to 1.
- req0 and req1 rise on the same edge (div0=4, div1=2) -> requester 0 served first, then requester 1; final div_out=2; exactly one ack0 and one ack1 pulse; the next tie goes to requester 0.
- req1 with div1=12 (>MAX_DIV) -> ack1 with err=1 one cycle after grant; div_out and clk_en_out unchanged; no gating.
- req0 with div0 equal to the current div_out -> ack0, err=0, clk_en_out never drops.
- Reset asserted during SETTLE -> immediate return to div_out=1, clk_en_out=0, no ack. After release, a held req0 is re-granted and completes normally.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Configuration controller for a programmable integer clock divider. Two
// requesters ask for a new divide ratio; requests are arbitrated round-robin and
// each accepted change is applied glitch-safely: gate the divider enable,
// load the new ratio, wait a settle interval, re-enable, then acknowledge.
//
// Ports:
//   CLK_Ref     reference clock, all logic on the rising edge
//   Reset       asynchronous active-high reset
//   div_en      software enable for the divided clock
//   req0/div0   requester 0 level request and requested ratio
//   req1/div1   requester 1 level request and requested ratio
//   ack0/ack1   one-cycle completion pulse to the granted requester
//   err         1 = request rejected (ratio above MAX_DIV); valid with ack
//   div_out     ratio to the divider
//   clk_en_out  enable to the divider
//   busy        high whenever a request is being processed
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned GATE_CYC   = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned MAX_DIV    = 8,
    parameter int unsigned RESET_DIV  = 1
) (
    input  logic       CLK_Ref,
    input  logic       Reset,
    input  logic       div_en,
    input  logic       req0,
    input  logic [3:0] div0,
    input  logic       req1,
    input  logic [3:0] div1,
    output logic       ack0,
    output logic       ack1,
    output logic       err,
    output logic [3:0] div_out,
    output logic       clk_en_out,
    output logic       busy
);

    localparam int unsigned DIV_W   = 4;
    localparam int unsigned CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DIV_W-1:0] MAX_DIV_V   = DIV_W'(MAX_DIV);
    localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);
    localparam logic [CNT_W-1:0] GATE_LD     = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD   = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_LOAD,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] r_div_out;
    logic             r_grant;
    logic             r_last_grant;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err;
    logic             r_clk_en;
    logic             r_busy;

    logic             w_req_any;
    logic             w_sel;
    logic [DIV_W-1:0] w_sel_div;

    // Round-robin pick: a lone request wins; on a tie the requester that was
    // not granted last time wins.
    assign w_req_any = req0 | req1;
    assign w_sel     = (req0 & req1) ? ~r_last_grant : req1;
    assign w_sel_div = w_sel ? div1 : div0;

    // Control FSM with registered outputs; ack/err default low so they pulse
    // only in the cycle spent in RESP.
    always_ff @(posedge CLK_Ref or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_pend_div   <= '0;
            r_div_out    <= RESET_DIV_V;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_clk_en     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_en <= div_en;
                    if (w_req_any) begin
                        r_last_grant <= w_sel;
                        r_grant      <= w_sel;
                        r_pend_div   <= w_sel_div;
                        r_busy       <= 1'b1;
                        if (w_sel_div > MAX_DIV_V) begin
                            // Illegal ratio: answer immediately, divider untouched.
                            r_state <= S_RESP;
                            r_ack0  <= ~w_sel;
                            r_ack1  <= w_sel;
                            r_err   <= 1'b1;
                        end else if (w_sel_div == r_div_out) begin
                            // Already at the requested ratio: no gating needed.
                            r_state <= S_RESP;
                            r_ack0  <= ~w_sel;
                            r_ack1  <= w_sel;
                        end else begin
                            r_state  <= S_GATE;
                            r_clk_en <= 1'b0;
                            r_count  <= GATE_LD;
                        end
                    end
                end
                S_GATE: begin
                    if (r_count == '0) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    r_div_out <= r_pend_div;
                    r_count   <= SETTLE_LD;
                    r_state   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_count == '0) begin
                        // Re-enable together with the ack so the enable is back
                        // in the ack cycle.
                        r_state  <= S_RESP;
                        r_ack0   <= ~r_grant;
                        r_ack1   <= r_grant;
                        r_clk_en <= div_en;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_clk_en <= div_en;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign err        = r_err;
    assign div_out    = r_div_out;
    assign clk_en_out = r_clk_en;
    assign busy       = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Scoreboard bench for clk_div_ctrl. Stimulus rounds push the expected ack
// sequence (computed from a requester-level model of the round-robin and
// ratio rules) into a queue; an independent monitor pops an entry on every
// ack and also watches the enable-gating window around each ratio change.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int unsigned G    = 2;
    localparam int unsigned S    = 4;
    localparam int unsigned MAXD = 8;
    localparam int unsigned RD   = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       div_en;
    logic       req0, req1;
    logic [3:0] div0, div1;
    logic       ack0, ack1, err, clk_en_out, busy;
    logic [3:0] div_out;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .GATE_CYC  (G),
        .SETTLE_CYC(S),
        .MAX_DIV   (MAXD),
        .RESET_DIV (RD)
    ) dut (
        .CLK_Ref   (clk),
        .Reset     (rst),
        .div_en    (div_en),
        .req0      (req0),
        .div0      (div0),
        .req1      (req1),
        .div1      (div1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .div_out   (div_out),
        .clk_en_out(clk_en_out),
        .busy      (busy)
    );

    typedef struct {
        bit       id;
        bit       err;
        bit [3:0] div;
        bit       gated;
        bit       en;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Requester-level model: current ratio and who wins the next tie.
    bit [3:0] m_div  = 4'(RD);
    bit       m_pref = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_grant(input bit id, input bit [3:0] d, input bit en);
        exp_t e;
        e.id  = id;
        e.en  = en;
        if (int'(d) > int'(MAXD)) begin
            e.err = 1'b1; e.gated = 1'b0; e.div = m_div;
        end else if (d == m_div) begin
            e.err = 1'b0; e.gated = 1'b0; e.div = m_div;
        end else begin
            e.err = 1'b0; e.gated = 1'b1; e.div = d;
            m_div = d;
        end
        m_pref = ~id;
        sbq.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every ack and checks gating windows.
    int       run = 0;
    int       low = 0;
    int       zb = 0;
    int       post = 0;
    logic [3:0] prev_div = 4'(RD);

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            run = 0; low = 0; zb = 0; post = 0;
            prev_div = div_out;
        end else begin
            if (div_out != prev_div) begin
                check("gate_before", int'(zb >= int'(G)), 1);
                post = int'(S);
            end
            if (post > 0) begin
                check("gate_after", int'(clk_en_out), 0);
                post--;
            end
            zb = clk_en_out ? 0 : zb + 1;
            prev_div = div_out;
            if (busy) begin
                run++;
                if (!clk_en_out) low++;
            end
            if (ack0 || ack1) begin
                check("ack_single", int'(ack0 && ack1), 0);
                if (sbq.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("ack_id", int'(ack1), int'(e.id));
                    check("err", int'(err), int'(e.err));
                    check("div_out", int'(div_out), int'(e.div));
                    check("busy_len", run, e.gated ? int'(G + S + 2) : 1);
                    check("en_low", low, (e.gated ? int'(G + S + 1) : 0) + int'(!e.en));
                    check("en_at_ack", int'(clk_en_out), int'(e.en));
                end
            end
            if (!busy) begin
                run = 0; low = 0;
            end
        end
    end

    // Wait for the raised requests to be acked and dropped; req1 may rise late.
    task automatic serve(input bit a1_late, input int dly, input bit drop_en);
        int cyc = 0;
        bit up1 = !a1_late;
        while ((req0 || req1 || !up1) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            if (!up1 && cyc == dly) begin
                req1 = 1'b1;
                up1  = 1'b1;
            end
            if (drop_en && cyc == 3) div_en = 1'b0;
        end
        check("round_done", int'(cyc < 400), 1);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        if (drop_en) begin
            div_en = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic round(input bit a0, input bit [3:0] d0, input bit a1,
                         input bit [3:0] d1, input int dly, input bit drop_en);
        bit tie = a0 && a1 && dly == 0;
        if (tie && m_pref) begin
            model_grant(1'b1, d1, 1'b1);
            model_grant(1'b0, d0, 1'b1);
        end else begin
            if (a0) model_grant(1'b0, d0, !drop_en);
            if (a1) model_grant(1'b1, d1, 1'b1);
        end
        @(negedge clk);
        div0 = d0;
        div1 = d1;
        req0 = a0;
        req1 = a1 && (dly == 0 || !a0);
        serve(a1 && a0 && dly > 0, dly, drop_en);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit [3:0] d;
        bit a0, a1;
        int dly;
        rst = 1'b1; div_en = 1'b1;
        req0 = 1'b0; req1 = 1'b0; div0 = '0; div1 = '0;
        repeat (3) @(negedge clk);
        check("rst_div", int'(div_out), int'(RD));
        check("rst_en", int'(clk_en_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(ack0 | ack1), 0);
        rst = 1'b0;
        #1 check("rel_en_low", int'(clk_en_out), 0);
        @(negedge clk);
        check("rel_en_high", int'(clk_en_out), 1);
        check("rel_busy", int'(busy), 0);

        // Idle follow of div_en with one cycle of latency.
        div_en = 1'b0;
        @(negedge clk);
        check("idle_en_off", int'(clk_en_out), 0);
        div_en = 1'b1;
        @(negedge clk);
        check("idle_en_on", int'(clk_en_out), 1);

        round(1'b1, 4'd4, 1'b1, 4'd2, 0, 1'b0);   // tie after reset
        check("tie_div", int'(div_out), 2);
        round(1'b1, 4'd3, 1'b1, 4'd5, 0, 1'b0);   // next tie
        round(1'b1, 4'd6, 1'b0, 4'd0, 0, 1'b0);
        check("div6", int'(div_out), 6);
        round(1'b0, 4'd0, 1'b1, 4'd12, 0, 1'b0);  // rejected
        round(1'b1, m_div, 1'b0, 4'd0, 0, 1'b0);  // no change
        round(1'b1, (m_div == 4'd3) ? 4'd5 : 4'd3, 1'b0, 4'd0, 0, 1'b1);
        round(1'b1, 4'd15, 1'b1, 4'd9, 0, 1'b0);  // both rejected
        round(1'b1, 4'd0, 1'b1, 4'd8, 2, 1'b0);   // late second request

        for (int i = 0; i < 40; i++) begin
            a0  = 1'($urandom_range(0, 1));
            a1  = 1'($urandom_range(0, 1));
            if (!a0 && !a1) a0 = 1'b1;
            dly = 0;
            if (a0 && a1 && $urandom_range(0, 2) != 0) dly = int'($urandom_range(1, 10));
            round(a0, 4'($urandom_range(0, 15)), a1, 4'($urandom_range(0, 15)), dly, 1'b0);
        end

        // Reset in the middle of SETTLE: pending request discarded, then regranted.
        d = (m_div == 4'd7) ? 4'd5 : 4'd7;
        @(negedge clk);
        div0 = d; req0 = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_div", int'(div_out), int'(d));
        check("pre_rst_busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_div", int'(div_out), int'(RD));
        check("mid_rst_en", int'(clk_en_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ack", int'(ack0 | ack1), 0);
        sbq.delete();
        m_div  = 4'(RD);
        m_pref = 1'b0;
        repeat (2) @(negedge clk);
        model_grant(1'b0, d, 1'b1);
        rst = 1'b0;
        serve(1'b0, 0, 1'b0);
        check("post_rst_div", int'(div_out), int'(d));

        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
